// File: rtl/video_stream_gen.sv
// video_stream_gen: raster timing and test-pattern source; VSTREAM_FRAME_CNT_EN adds the vout_frame_cnt output
module video_stream_gen #(
    parameter int   H_SYNC  = 40,
    parameter int   H_BACK  = 220,
    parameter int   H_DISP  = 1280,
    parameter int   H_FRONT = 110,
    parameter int   V_SYNC  = 5,
    parameter int   V_BACK  = 20,
    parameter int   V_DISP  = 720,
    parameter int   V_FRONT = 5,
    parameter int   CH      = 3,
    parameter int   DW      = 8,
    parameter logic HS_POL  = 1'b1,
    parameter logic VS_POL  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vout_begin,
    input  logic             vout_cont,
    input  logic             vout_stop,
    input  logic [1:0]       pat_sel,
    output logic             vout_vsync,
    output logic             vout_hsync,
    output logic             vout_valid,
    output logic [CH*DW-1:0] vout_dat,
    output logic             vout_done,
    output logic             vout_busy,
    output logic [15:0]      vout_xres,
    output logic [15:0]      vout_yres
`ifdef VSTREAM_FRAME_CNT_EN
    ,
    output logic [15:0]      vout_frame_cnt
`endif
);
    localparam int          XW       = DW > 5 ? DW : 5;
    localparam logic [15:0] H_LAST   = 16'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
    localparam logic [15:0] V_LAST   = 16'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
    localparam logic [15:0] H_A0     = 16'(H_SYNC + H_BACK);
    localparam logic [15:0] H_A1     = 16'(H_SYNC + H_BACK + H_DISP);
    localparam logic [15:0] V_A0     = 16'(V_SYNC + V_BACK);
    localparam logic [15:0] V_A1     = 16'(V_SYNC + V_BACK + V_DISP);
    localparam logic [15:0] H_S      = 16'(H_SYNC);
    localparam logic [15:0] V_S      = 16'(V_SYNC);
    localparam logic [15:0] BAR_LAST = 16'(H_DISP / 8 - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [15:0]      col, row, col_nxt, row_nxt, bar_cnt;
    logic [2:0]       bar;
    logic [1:0]       pat_q, pat_cur;
    logic [XW-1:0]    x, y;
    logic [CH*DW-1:0] px;
    logic             begin_q, start, run, h_end, last, active;

    assign vout_xres = 16'(H_DISP);
    assign vout_yres = 16'(V_DISP);
    assign vout_busy = run;
    assign run       = state == RUN;
    assign start     = vout_begin & ~begin_q;
    assign h_end     = col == H_LAST;
    assign last      = h_end && row == V_LAST;
    assign active    = run && col >= H_A0 && col < H_A1 && row >= V_A0 && row < V_A1;
    assign x         = XW'(col - H_A0);
    assign y         = XW'(row - V_A0);
    assign pat_cur   = (col == 16'd0 && row == 16'd0) ? pat_sel : pat_q;

    always_comb begin
        state_nxt = run ? ((last && !(vout_cont && !vout_stop)) ? IDLE : RUN) : (start ? RUN : IDLE);
        col_nxt   = (run && !h_end) ? col + 16'd1 : 16'd0;
        row_nxt   = !run ? 16'd0 : h_end ? (row == V_LAST ? 16'd0 : row + 16'd1) : row;
    end

    // bar bit (c mod 3) of 7-b is the inverted bit of b
    always_comb begin
        px = '0;
        for (int c = 0; c < CH; c++)
            px[c*DW +: DW] = pat_cur == 2'd0 ? x[DW-1:0] : pat_cur == 2'd1 ? y[DW-1:0] :
                             {DW{pat_cur == 2'd2 ? ~bar[c % 3] : x[4] ^ y[4]}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            begin_q    <= 1'b0;
            pat_q      <= '0;
            bar        <= '0;
            bar_cnt    <= '0;
            vout_hsync <= ~HS_POL;
            vout_vsync <= ~VS_POL;
            vout_valid <= 1'b0;
            vout_dat   <= '0;
            vout_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            col        <= col_nxt;
            row        <= row_nxt;
            begin_q    <= vout_begin;
            pat_q      <= pat_cur;
            bar_cnt    <= (active && bar_cnt != BAR_LAST) ? bar_cnt + 16'd1 : 16'd0;
            bar        <= !active ? 3'd0 : bar_cnt == BAR_LAST ? bar + 3'd1 : bar;
            vout_hsync <= (run && col < H_S) ? HS_POL : ~HS_POL;
            vout_vsync <= (run && row < V_S) ? VS_POL : ~VS_POL;
            vout_valid <= active;
            vout_dat   <= active ? px : '0;
            vout_done  <= run && last;
        end
    end

`ifdef VSTREAM_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vout_frame_cnt <= '0;
        else
            vout_frame_cnt <= (!run && start) ? 16'd0 : (run && last) ? vout_frame_cnt + 16'd1 : vout_frame_cnt;
    end
`endif
endmodule

// File: tb/tb_video_stream_gen.sv
// tb_video_stream_gen: directed bench for two rasters (positive and negative sync polarity)
module tb_video_stream_gen;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        b0 = 0, c0 = 0, s0 = 0, b1 = 0, c1 = 0, s1 = 0;
    logic [1:0]  p0 = 0, p1 = 0;
    logic        vs0, hs0, va0, dn0, bz0, vs1, hs1, va1, dn1, bz1;
    logic [23:0] dat0, dat1;
    logic [15:0] xr0, yr0, xr1, yr1;
`ifdef VSTREAM_FRAME_CNT_EN
    logic [15:0] fc0, fc1;
`endif
    int nchk = 0, nerr = 0;
    int k, n, nva, nhs, nvs, ndn, nbz;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'hFF00FF, 24'hFF0000,
                              24'h00FFFF, 24'h00FF00, 24'h0000FF, 24'h000000};
    logic [23:0] e;

    always #5 clk = ~clk;

    video_stream_gen #(.H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_FRONT(2), .V_SYNC(1), .V_BACK(1),
                       .V_DISP(4), .V_FRONT(1), .CH(3), .DW(8), .HS_POL(1'b1), .VS_POL(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .vout_begin(b0), .vout_cont(c0), .vout_stop(s0), .pat_sel(p0),
        .vout_vsync(vs0), .vout_hsync(hs0), .vout_valid(va0), .vout_dat(dat0), .vout_done(dn0),
        .vout_busy(bz0), .vout_xres(xr0), .vout_yres(yr0)
`ifdef VSTREAM_FRAME_CNT_EN
        , .vout_frame_cnt(fc0)
`endif
    );

    video_stream_gen #(.H_SYNC(2), .H_BACK(2), .H_DISP(32), .H_FRONT(2), .V_SYNC(1), .V_BACK(1),
                       .V_DISP(2), .V_FRONT(1), .CH(3), .DW(8), .HS_POL(1'b0), .VS_POL(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .vout_begin(b1), .vout_cont(c1), .vout_stop(s1), .pat_sel(p1),
        .vout_vsync(vs1), .vout_hsync(hs1), .vout_valid(va1), .vout_dat(dat1), .vout_done(dn1),
        .vout_busy(bz1), .vout_xres(xr1), .vout_yres(yr1)
`ifdef VSTREAM_FRAME_CNT_EN
        , .vout_frame_cnt(fc1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        check("rst_hs0", hs0, 0);
        check("rst_vs0", vs0, 0);
        check("rst_va0", va0, 0);
        check("rst_dat0", dat0, 0);
        check("rst_dn0", dn0, 0);
        check("rst_bz0", bz0, 0);
        check("rst_hs1", hs1, 1);
        check("rst_vs1", vs1, 1);
        check("xres0", xr0, 8);
        check("yres0", yr0, 4);
        check("xres1", xr1, 32);
`ifdef VSTREAM_FRAME_CNT_EN
        check("rst_fc0", fc0, 0);
`endif
        #1 rst_n = 1'b1;
        tick();
        // single frame, ramp, small raster
        b0 = 1;
        tick();
        b0 = 0;
        check("t1_busy_start", bz0, 1);
        k = 0; nva = 0; nhs = 0; nvs = 0; ndn = 0; nbz = 1;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (va0) begin
                e = {3{8'(k % 8)}};
                check("t1_ramp", dat0, e);
                k++;
                nva++;
            end
            if (hs0) nhs++;
            if (vs0) nvs++;
            if (bz0) nbz++;
            if (dn0) begin
                ndn++;
                check("t1_busy_at_done", bz0, 0);
            end
        end
        check("t1_valid_cnt", nva, 32);
        check("t1_hsync_cnt", nhs, 14);
        check("t1_vsync_cnt", nvs, 14);
        check("t1_done_cnt", ndn, 1);
        check("t1_busy_cycles", nbz, 98);
        check("t1_busy_end", bz0, 0);
        // continuous, stop during frame 3
        c0 = 1;
        b0 = 1;
        tick();
        b0 = 0;
        ndn = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (dn0) ndn++;
            if (i == 250) s0 = 1;
        end
        check("t2_done_cnt", ndn, 3);
        check("t2_busy_end", bz0, 0);
`ifdef VSTREAM_FRAME_CNT_EN
        check("t2_frame_cnt", fc0, 3);
`endif
        c0 = 0;
        s0 = 0;
        // colour bars, negative syncs, ignored second edge
        p1 = 2;
        b1 = 1;
        tick();
        b1 = 0;
        check("t3_busy_start", bz1, 1);
        k = 0; nhs = 0; nvs = 0; ndn = 0; nbz = 1;
        for (int i = 0; i < 220; i++) begin
            tick();
            if (i == 60) b1 = 1;
            if (i == 61) b1 = 0;
            if (!hs1) nhs++;
            if (!vs1) nvs++;
            if (bz1) nbz++;
            if (dn1) ndn++;
            if (va1) begin
                check("t3_bar", dat1, bars[(k % 32) / 4]);
                k++;
            end
        end
        check("t3_valid_cnt", k, 64);
        check("t3_hsync_lo", nhs, 10);
        check("t3_vsync_lo", nvs, 38);
        check("t3_done_cnt", ndn, 1);
        check("t3_busy_cycles", nbz, 190);
`ifdef VSTREAM_FRAME_CNT_EN
        check("t3_frame_cnt", fc1, 1);
`endif
        // pattern change mid-frame takes effect next frame
        p1 = 0;
        c1 = 1;
        b1 = 1;
        tick();
        b1 = 0;
        k = 0; ndn = 0;
        for (int i = 0; i < 450; i++) begin
            tick();
            if (i == 50) p1 = 3;
            if (dn1) begin
                ndn++;
                s1 = 1;
            end
            if (va1) begin
                e = k < 64 ? {3{8'(k % 32)}} : ((k % 32) >= 16 ? 24'hFFFFFF : 24'h000000);
                check(k < 64 ? "t4_ramp" : "t4_checker", dat1, e);
                k++;
            end
        end
        check("t4_valid_cnt", k, 128);
        check("t4_done_cnt", ndn, 2);
        check("t4_busy_end", bz1, 0);
        c1 = 0;
        s1 = 0;
        // async reset at row 3, begin held high across release
        b0 = 1;
        tick();
        for (int i = 0; i < 47; i++) tick();
        check("t5_pre_valid", va0, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_va0", va0, 0);
        check("t5_dat0", dat0, 0);
        check("t5_bz0", bz0, 0);
        check("t5_dn0", dn0, 0);
        check("t5_hs0", hs0, 0);
        check("t5_vs0", vs0, 0);
        check("t5_hs1", hs1, 1);
        check("t5_vs1", vs1, 1);
        #3 rst_n = 1'b1;
        tick();
        check("t5_restart_busy", bz0, 1);
        n = 0;
        for (int i = 0; i < 60 && !va0; i++) begin
            tick();
            n++;
        end
        check("t5_first_valid_lat", n, 33);
        check("t5_first_pixel", dat0, 0);
        b0 = 0;
        for (int i = 0; i < 80; i++) tick();
        check("t5_busy_end", bz0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end
endmodule
